accel_avg_filter: RTL

//  Downstream consumer of the SPI accelerometer controller. Captures each X/Y/Z sample set on
//  the data_update pulse and keeps a per-axis ring buffer of the last 2**DEPTH_LOG2 samples.

---
 rtl/accel_pkg.sv | 18 +
 rtl/avg_ring_buffer.sv | 34 +++
 rtl/accel_avg_filter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared accelerometer constants, axis indices and filter FSM states
package accel_pkg;

  localparam int ACCEL_DATA_W = 16;

  localparam logic [1:0] AX_X = 2'd0;
  localparam logic [1:0] AX_Y = 2'd1;
  localparam logic [1:0] AX_Z = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACC_X   = 3'd1,
    ST_ACC_Y   = 3'd2,
    ST_ACC_Z   = 3'd3,
    ST_PUBLISH = 3'd4
  } filt_state_t;

endpackage

// File: rtl/avg_ring_buffer.sv
// rtl/avg_ring_buffer.sv - per-axis sample history, one axis-selected read/write port
module avg_ring_buffer #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            axis,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [3][DEPTH];

  // Read returns the slot about to be overwritten, so the sum can drop it in the same cycle.
  assign rd_data = mem[axis][addr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int a = 0; a < 3; a++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[a][i] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[axis][addr] <= wr_data;
    end
  end

endmodule

// File: rtl/accel_avg_filter.sv
// rtl/accel_avg_filter.sv - per-axis boxcar moving average; ACCEL_FILT_DEADBAND_EN enables publish deadband
module accel_avg_filter
  import accel_pkg::*;
#(
  parameter int DATA_W     = ACCEL_DATA_W,
  parameter int DEPTH_LOG2 = 3,
  parameter int DEADBAND   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              data_update,
  input  logic [DATA_W-1:0] data_x,
  input  logic [DATA_W-1:0] data_y,
  input  logic [DATA_W-1:0] data_z,
  output logic [DATA_W-1:0] avg_x,
  output logic [DATA_W-1:0] avg_y,
  output logic [DATA_W-1:0] avg_z,
  output logic              avg_valid,
  output logic              filled,
  output logic              overrun
);

  localparam int SUM_W = DATA_W + DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
`ifdef ACCEL_FILT_DEADBAND_EN
  localparam logic [DATA_W:0] DB_THR = (DATA_W+1)'(DEADBAND);
`else
  // A zero threshold lets every axis through on every sample.
  localparam logic [DATA_W:0] DB_THR = (DATA_W+1)'(DEADBAND * 0);
`endif

  filt_state_t state;
  logic signed [DATA_W-1:0] hold_x, hold_y, hold_z;
  logic signed [SUM_W-1:0]  sum_x, sum_y, sum_z;
  logic [DEPTH_LOG2-1:0]    wr_ptr;
  logic [DEPTH_LOG2:0]      fill_cnt;

  logic [1:0]               axis;
  logic                     buf_we;
  logic signed [DATA_W-1:0] hold_sel;
  logic signed [DATA_W-1:0] old;
  logic signed [SUM_W-1:0]  sum_sel, sum_next;
  logic [DATA_W-1:0]        new_x, new_y, new_z;
  logic                     upd_x, upd_y, upd_z;

  function automatic logic moved(input logic [DATA_W-1:0] nv, input logic [DATA_W-1:0] ov);
    logic signed [DATA_W:0] d;
    logic [DATA_W:0]        mag;
    d   = $signed({nv[DATA_W-1], nv}) - $signed({ov[DATA_W-1], ov});
    mag = d[DATA_W] ? $unsigned(-d) : $unsigned(d);
    return mag >= DB_THR;
  endfunction

  avg_ring_buffer #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .axis    (axis),
    .addr    (wr_ptr),
    .wr_en   (buf_we),
    .wr_data (hold_sel),
    .rd_data (old)
  );

  always_comb begin
    axis     = AX_X;
    hold_sel = hold_x;
    sum_sel  = sum_x;
    buf_we   = 1'b0;
    case (state)
      ST_ACC_X: begin axis = AX_X; hold_sel = hold_x; sum_sel = sum_x; buf_we = 1'b1; end
      ST_ACC_Y: begin axis = AX_Y; hold_sel = hold_y; sum_sel = sum_y; buf_we = 1'b1; end
      ST_ACC_Z: begin axis = AX_Z; hold_sel = hold_z; sum_sel = sum_z; buf_we = 1'b1; end
      default: ;
    endcase
  end

  assign sum_next = sum_sel - SUM_W'(old) + SUM_W'(hold_sel);

  // Averages are formed while leaving ACC_Z (Z from sum_next) so they show during PUBLISH.
  assign new_x = sum_x[SUM_W-1:DEPTH_LOG2];
  assign new_y = sum_y[SUM_W-1:DEPTH_LOG2];
  assign new_z = sum_next[SUM_W-1:DEPTH_LOG2];
  assign upd_x = moved(new_x, avg_x);
  assign upd_y = moved(new_y, avg_y);
  assign upd_z = moved(new_z, avg_z);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      hold_x    <= '0;
      hold_y    <= '0;
      hold_z    <= '0;
      sum_x     <= '0;
      sum_y     <= '0;
      sum_z     <= '0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      avg_x     <= '0;
      avg_y     <= '0;
      avg_z     <= '0;
      avg_valid <= 1'b0;
      filled    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (data_update && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (data_update) begin
            hold_x <= data_x;
            hold_y <= data_y;
            hold_z <= data_z;
            state  <= ST_ACC_X;
          end
        end
        ST_ACC_X: begin
          sum_x <= sum_next;
          state <= ST_ACC_Y;
        end
        ST_ACC_Y: begin
          sum_y <= sum_next;
          state <= ST_ACC_Z;
        end
        ST_ACC_Z: begin
          sum_z  <= sum_next;
          wr_ptr <= wr_ptr + 1'b1;
          if (fill_cnt != FULL) fill_cnt <= fill_cnt + 1'b1;
          filled <= (fill_cnt == FULL - 1'b1) || (fill_cnt == FULL);
          if (upd_x) avg_x <= new_x;
          if (upd_y) avg_y <= new_y;
          if (upd_z) avg_z <= new_z;
          avg_valid <= upd_x | upd_y | upd_z;
          state     <= ST_PUBLISH;
        end
        ST_PUBLISH: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule
